// File: rtl/switch_input.sv
// Operator-input front end: synchronises the data switches, debounces the
// confirm switch and hands the processor one latched word per confirm gesture
// through a level req / valid handshake.
module switch_input #(
    parameter int unsigned DATA_W          = 17,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              sw_confirm,
    input  logic              req,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic [DATA_W-1:0] preview,
    output logic              waiting
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned LAST_STG = SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM_LOW  = 3'd1,
        ARMED    = 3'd2,
        CAPTURED = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync;
    logic [SYNC_STAGES-1:0]             conf_sync;
    logic [DATA_W-1:0]                  data_s;
    logic                               conf_s;

    logic [CNT_W-1:0]                   db_cnt;
    logic                               conf_db;
    logic                               conf_rise;
    logic                               conf_fall;
    logic                               db_terminal_c;

    state_t                             state;

    assign data_s        = data_sync[LAST_STG];
    assign conf_s        = conf_sync[LAST_STG];
    assign preview       = data_s;
    assign db_terminal_c = (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Multi-flop synchroniser on every switch input; the last stage is the preview.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_sync <= '0;
            conf_sync <= '0;
        end else begin
            data_sync <= {data_sync[SYNC_STAGES-2:0], sw_data};
            conf_sync <= {conf_sync[SYNC_STAGES-2:0], sw_confirm};
        end
    end

    // Debounce: the confirm level only moves after a full run of stable disagreement.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt    <= '0;
            conf_db   <= 1'b0;
            conf_rise <= 1'b0;
            conf_fall <= 1'b0;
        end else begin
            conf_rise <= 1'b0;
            conf_fall <= 1'b0;
            if (conf_s == conf_db) begin
                db_cnt <= '0;
            end else if (db_terminal_c) begin
                db_cnt    <= '0;
                conf_db   <= ~conf_db;
                conf_rise <= ~conf_db;
                conf_fall <= conf_db;
            end else begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // Handshake FSM: a capture needs a fresh debounced low->high while req is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            data    <= '0;
            valid   <= 1'b0;
            waiting <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // A switch already up at request time must be cycled first.
                        state   <= conf_db ? ARM_LOW : ARMED;
                        waiting <= 1'b1;
                    end
                end
                ARM_LOW: begin
                    if (!req) begin
                        state   <= IDLE;
                        waiting <= 1'b0;
                    end else if (conf_fall) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // Dropping req wins over a coincident confirm edge.
                    if (!req) begin
                        state   <= IDLE;
                        waiting <= 1'b0;
                    end else if (conf_rise) begin
                        state   <= CAPTURED;
                        data    <= data_s;
                        valid   <= 1'b1;
                        waiting <= 1'b0;
                    end
                end
                CAPTURED: begin
                    if (!req) begin
                        state <= RELEASE;
                        valid <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!conf_db) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid   <= 1'b0;
                    waiting <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_input.sv
// Directed bench for switch_input with a capture scoreboard.
module tb_switch_input;

    localparam int unsigned DATA_W = 17;

    logic              clock;
    logic              reset_n;
    logic [DATA_W-1:0] sw_data;
    logic              sw_confirm;
    logic              req;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic [DATA_W-1:0] preview;
    logic              waiting;

    int errors = 0;
    int checks = 0;
    int captures = 0;
    int chatter_valid = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic valid_q = 1'b0;

    switch_input #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sw_data(sw_data),
        .sw_confirm(sw_confirm),
        .req(req),
        .data(data),
        .valid(valid),
        .preview(preview),
        .waiting(waiting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every new valid must match the oldest queued expected word.
    always @(negedge clock) begin
        if (valid && !valid_q) begin
            captures++;
            if (exp_q.size() == 0) begin
                check("unexpected_capture", 32'(data), 32'hFFFF_FFFF);
            end else begin
                check("capture_data", 32'(data), 32'(exp_q.pop_front()));
            end
        end
        valid_q = valid;
    end

    initial begin
        reset_n    = 1'b0;
        sw_data    = 17'h1ABCD;
        sw_confirm = 1'b1;
        req        = 1'b0;

        // 1: reset values, then preview follows the switches
        tick(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_preview", 32'(preview), 32'd0);
        check("rst_waiting", 32'(waiting), 32'd0);
        reset_n = 1'b1;
        tick(3);
        check("preview_after_rst", 32'(preview), 32'h1ABCD);
        sw_confirm = 1'b0;
        tick(12);
        check("idle_valid", 32'(valid), 32'd0);

        // 2: normal gesture
        sw_data = 17'h00123;
        req     = 1'b1;
        tick(2);
        check("t2_waiting", 32'(waiting), 32'd1);
        exp_q.push_back(17'h00123);
        sw_confirm = 1'b1;
        tick(6);
        check("t2_not_yet_valid", 32'(valid), 32'd0);
        tick(4);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_data", 32'(data), 32'h00123);
        check("t2_waiting_done", 32'(waiting), 32'd0);
        req = 1'b0;
        tick(1);
        check("t2_valid_drop", 32'(valid), 32'd0);
        check("t2_data_kept", 32'(data), 32'h00123);
        sw_confirm = 1'b0;
        tick(10);

        // 3: chatter then a firm press gives exactly one capture
        sw_data = 17'h0AAAA;
        req     = 1'b1;
        exp_q.push_back(17'h0AAAA);
        for (int i = 0; i < 20; i++) begin
            sw_confirm = ((i % 4) < 2);
            tick(1);
            if (valid) chatter_valid++;
        end
        check("t3_chatter_valid", 32'(chatter_valid), 32'd0);
        check("t3_waiting", 32'(waiting), 32'd1);
        sw_confirm = 1'b1;
        tick(10);
        check("t3_valid", 32'(valid), 32'd1);
        check("t3_data", 32'(data), 32'h0AAAA);
        req = 1'b0;
        tick(1);
        sw_confirm = 1'b0;
        tick(10);

        // 4: stale high switch must be cycled before a capture
        sw_confirm = 1'b1;
        tick(10);
        sw_data = 17'h15555;
        req     = 1'b1;
        tick(6);
        check("t4_stale_valid", 32'(valid), 32'd0);
        check("t4_stale_waiting", 32'(waiting), 32'd1);
        sw_confirm = 1'b0;
        tick(10);
        check("t4_low_valid", 32'(valid), 32'd0);
        check("t4_low_waiting", 32'(waiting), 32'd1);
        sw_data = 17'h1F0F0;
        exp_q.push_back(17'h1F0F0);
        sw_confirm = 1'b1;
        tick(10);
        check("t4_valid", 32'(valid), 32'd1);
        check("t4_data", 32'(data), 32'h1F0F0);
        req = 1'b0;
        tick(1);
        sw_confirm = 1'b0;
        tick(10);

        // 5: abort before confirm
        sw_data = 17'h00001;
        req     = 1'b1;
        tick(3);
        check("t5_waiting", 32'(waiting), 32'd1);
        req = 1'b0;
        tick(2);
        check("t5_waiting_off", 32'(waiting), 32'd0);
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_data_kept", 32'(data), 32'h1F0F0);
        sw_confirm = 1'b1;
        tick(10);
        check("t5_no_capture", 32'(valid), 32'd0);
        sw_confirm = 1'b0;
        tick(10);

        // 6: reset while a word is presented
        sw_data = 17'h00777;
        req     = 1'b1;
        tick(2);
        exp_q.push_back(17'h00777);
        sw_confirm = 1'b1;
        tick(10);
        check("t6_valid", 32'(valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_data", 32'(data), 32'd0);
        check("t6_rst_waiting", 32'(waiting), 32'd0);
        req        = 1'b0;
        sw_confirm = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(10);

        check("capture_count", 32'(captures), 32'd4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
